// File: rtl/plank_proto_pkg.sv
// plank_proto_pkg: shared framing constants and state types
// for the controller<->plank UART protocol.
package plank_proto_pkg;

   localparam logic [7:0] HDR       = 8'hAA;
   localparam logic [7:0] FTR       = 8'h55;
   localparam logic [7:0] CMD_PLANK = 8'hE2;
   localparam logic [7:0] RSP_ACK   = 8'hEE;
   localparam logic [7:0] RSP_NACK  = 8'hEF;

   localparam int PLANK_FRAME_LEN = 22;
   localparam int RSP_FRAME_LEN   = 7;
   localparam int N_ATT           = 17;
   localparam int ATT_W           = 6;

   typedef enum logic [2:0] {
      P_HUNT,
      P_CMD,
      P_DATA,
      P_ID,
      P_CSUM,
      P_FOOT
   } parse_st_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_SEND,
      R_WAIT_DONE
   } resp_st_t;

endpackage

// File: rtl/plank_resp_tx.sv
// plank_resp_tx: 7-byte ACK/NACK telemetry sequencer,
// running checksum and UART TX strobe/done handshake.
module plank_resp_tx #(
   parameter logic [23:0] TEMP = 24'h2050DD
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_ack,
   input  logic       i_tx_done,
   output logic       o_tx_dv,
   output logic [7:0] o_tx_byte,
   output logic       o_busy
);
   import plank_proto_pkg::*;

   localparam logic [2:0] LAST = 3'(RSP_FRAME_LEN - 1);

   resp_st_t   st;
   logic [2:0] idx;
   logic       ack_q;
   logic [7:0] csum;
   logic [2:0] nxt_idx;
   logic [7:0] nxt_byte;

   assign nxt_idx = idx + 3'd1;

   // select the byte that follows the one currently on the line
   always_comb begin
      nxt_byte = FTR;
      case (nxt_idx)
         3'd1:    nxt_byte = ack_q ? RSP_ACK : RSP_NACK;
         3'd2:    nxt_byte = TEMP[23:16];
         3'd3:    nxt_byte = TEMP[15:8];
         3'd4:    nxt_byte = TEMP[7:0];
         3'd5:    nxt_byte = csum;
         default: nxt_byte = FTR;
      endcase
   end

   // sequencer: strobe one byte, wait for done, repeat until footer
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         st        <= R_IDLE;
         idx       <= 3'd0;
         ack_q     <= 1'b0;
         csum      <= 8'h00;
         o_tx_dv   <= 1'b0;
         o_tx_byte <= 8'h00;
         o_busy    <= 1'b0;
      end else begin
         o_tx_dv <= 1'b0;
         unique case (st)
            R_IDLE: begin
               if (i_start) begin
                  st        <= R_SEND;
                  idx       <= 3'd0;
                  ack_q     <= i_ack;
                  csum      <= HDR;
                  o_tx_byte <= HDR;
                  o_tx_dv   <= 1'b1;
                  o_busy    <= 1'b1;
               end
            end
            R_SEND: begin
               st <= R_WAIT_DONE;
            end
            R_WAIT_DONE: begin
               if (i_tx_done) begin
                  if (idx == LAST) begin
                     st     <= R_IDLE;
                     o_busy <= 1'b0;
                  end else begin
                     st        <= R_SEND;
                     idx       <= nxt_idx;
                     o_tx_byte <= nxt_byte;
                     csum      <= csum ^ nxt_byte;
                     o_tx_dv   <= 1'b1;
                  end
               end
            end
            default: st <= R_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/plank_frame_responder.sv
// plank_frame_responder: parses the 22-byte plank config
// frame, commits attenuations and triggers ACK/NACK replies.
module plank_frame_responder #(
   parameter logic [2:0]  PLANK_ID    = 3'd0,
   parameter logic [23:0] TEMP        = 24'h2050DD,
   parameter int          TIMEOUT_CYC = 200000
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_rx_dv,
   input  logic [7:0]   i_rx_byte,
   output logic         o_tx_dv,
   output logic [7:0]   o_tx_byte,
   input  logic         i_tx_done,
   output logic [101:0] o_att,
   output logic         o_att_valid,
   output logic         o_busy,
   output logic [7:0]   o_err_cnt
);
   import plank_proto_pkg::*;

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);
   localparam logic [4:0] LAST_ATT = 5'(N_ATT - 1);

   parse_st_t                        st;
   logic [4:0]                       idx;
   logic [7:0]                       csum;
   logic                             fmt_err;
   logic                             id_match;
   logic                             csum_ok;
   logic [N_ATT-1:0][ATT_W-1:0]      shadow;
   logic [TMO_W-1:0]                 tmo;
   logic                             rx_ok;
   logic                             foot_hit;
   logic                             frame_ok;

   assign rx_ok    = i_rx_dv && !o_busy;
   assign frame_ok = csum_ok && !fmt_err && (i_rx_byte == FTR);
   assign foot_hit = rx_ok && (st == P_FOOT) && id_match;

   // byte parser, idle timeout and attenuation commit
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         st          <= P_HUNT;
         idx         <= 5'd0;
         csum        <= 8'h00;
         fmt_err     <= 1'b0;
         id_match    <= 1'b0;
         csum_ok     <= 1'b0;
         shadow      <= '0;
         tmo         <= '0;
         o_att       <= '0;
         o_att_valid <= 1'b0;
         o_err_cnt   <= 8'h00;
      end else begin
         o_att_valid <= 1'b0;
         if (o_busy) begin
            st  <= P_HUNT;
            tmo <= '0;
         end else if (i_rx_dv) begin
            tmo <= '0;
            unique case (st)
               P_HUNT: begin
                  if (i_rx_byte == HDR) begin
                     st      <= P_CMD;
                     csum    <= HDR;
                     fmt_err <= 1'b0;
                  end
               end
               P_CMD: begin
                  if (i_rx_byte == CMD_PLANK) begin
                     st   <= P_DATA;
                     idx  <= 5'd0;
                     csum <= csum ^ i_rx_byte;
                  end else begin
                     st <= P_HUNT;
                  end
               end
               P_DATA: begin
                  shadow[idx] <= i_rx_byte[5:0];
                  csum        <= csum ^ i_rx_byte;
                  if (i_rx_byte[7:6] != 2'b00) fmt_err <= 1'b1;
                  if (idx == LAST_ATT) st <= P_ID;
                  idx <= idx + 5'd1;
               end
               P_ID: begin
                  id_match <= (i_rx_byte == {5'b0, PLANK_ID});
                  csum     <= csum ^ i_rx_byte;
                  st       <= P_CSUM;
               end
               P_CSUM: begin
                  csum_ok <= (i_rx_byte == csum);
                  st      <= P_FOOT;
               end
               P_FOOT: begin
                  if (id_match) begin
                     if (frame_ok) begin
                        o_att       <= shadow;
                        o_att_valid <= 1'b1;
                     end else if (o_err_cnt != 8'hFF) begin
                        o_err_cnt <= o_err_cnt + 8'd1;
                     end
                  end
                  st <= P_HUNT;
               end
               default: st <= P_HUNT;
            endcase
         end else if (st != P_HUNT) begin
            if (tmo == TMO_MAX) begin
               st  <= P_HUNT;
               tmo <= '0;
            end else begin
               tmo <= tmo + 1'b1;
            end
         end
      end
   end

   plank_resp_tx #(
      .TEMP (TEMP)
   ) u_resp_tx (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_start   (foot_hit),
      .i_ack     (frame_ok),
      .i_tx_done (i_tx_done),
      .o_tx_dv   (o_tx_dv),
      .o_tx_byte (o_tx_byte),
      .o_busy    (o_busy)
   );

endmodule
